// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash engine between two requesters.
// Launches frames, detects completion on CS, enforces a CS-high gap and recovers a hung engine.
module spi_flash_arbiter #(
  parameter int          GAP_CYCLES = 4,
  parameter int          TIMEOUT    = 255,
  parameter int          RST_CYCLES = 2,
  parameter logic [7:0]  CMD_WR0    = 8'h56,
  parameter logic [7:0]  CMD_WR1    = 8'hE9,
  parameter logic [7:0]  CMD_RD     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_cmd,
  input  logic [23:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [7:0]  req1_cmd,
  input  logic [23:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  output logic        m_enable,
  output logic [7:0]  m_commands,
  output logic [23:0] m_address,
  output logic [31:0] m_data_out,
  output logic        m_rst,
  input  logic        m_cs,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, BUSY, RECOVER, GAP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  state_t      state, state_next;
  logic        winner, rr_last, bad_done;
  logic [7:0]  cnt;
  logic        win_valid, legal, grant_ok, frame_done, frame_err;
  logic [7:0]  win_cmd;

  assign win_valid = winner ? req1_valid : req0_valid;
  assign win_cmd   = winner ? req1_cmd   : req0_cmd;
  assign legal     = (win_cmd == CMD_WR0) || (win_cmd == CMD_WR1) || (win_cmd == CMD_RD);

  always_comb begin
    state_next = state;
    grant_ok   = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE:    if (req0_valid || req1_valid) state_next = GRANT;
      // A winner that dropped valid before ready has withdrawn its request.
      GRANT: begin
        if (!win_valid) state_next = IDLE;
        else begin
          grant_ok   = 1'b1;
          state_next = legal ? LAUNCH : IDLE;
        end
      end
      LAUNCH: begin
        if (!m_cs)                 state_next = BUSY;
        else if (cnt == TMO_LAST)  state_next = RECOVER;
      end
      BUSY: begin
        if (m_cs) begin
          frame_done = 1'b1;
          state_next = GAP;
        end else if (cnt == TMO_LAST) state_next = RECOVER;
      end
      RECOVER: begin
        if (cnt == RST_LAST) begin
          frame_done = 1'b1;
          frame_err  = 1'b1;
          state_next = GAP;
        end
      end
      GAP:     if (m_cs && cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One shared timer; it keeps running across LAUNCH->BUSY so the timeout spans the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      winner     <= 1'b0;
      bad_done   <= 1'b0;
      cnt        <= 8'd0;
      m_commands <= 8'd0;
      m_address  <= 24'd0;
      m_data_out <= 32'd0;
    end else begin
      state    <= state_next;
      bad_done <= grant_ok && !legal;
      if (state == IDLE)
        winner <= (req0_valid && req1_valid) ? ~rr_last : req1_valid;
      if (grant_ok) begin
        rr_last    <= winner;
        m_commands <= win_cmd;
        m_address  <= winner ? req1_addr  : req0_addr;
        m_data_out <= winner ? req1_wdata : req0_wdata;
      end
      if (state_next != state && !(state == LAUNCH && state_next == BUSY))
        cnt <= 8'd0;
      else if (state == GAP && !m_cs)
        cnt <= 8'd0;
      else if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;
    end
  end

  assign req0_ready = grant_ok && !winner && !rst;
  assign req1_ready = grant_ok &&  winner && !rst;
  assign req0_done  = (frame_done || bad_done) && !winner && !rst;
  assign req1_done  = (frame_done || bad_done) &&  winner && !rst;
  assign req0_err   = (frame_err  || bad_done) && !winner && !rst;
  assign req1_err   = (frame_err  || bad_done) &&  winner && !rst;
  assign m_enable   = (state == LAUNCH) && !rst;
  assign m_rst      = rst || (state == RECOVER);
  assign busy       = (state != IDLE) && !rst;
  assign state_dbg  = state;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter with a small behavioural SPI engine driving m_cs.
module tb_spi_flash_arbiter;

  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 255;
  localparam int FRAME      = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_cmd = 8'd0, req1_cmd = 8'd0;
  logic [23:0] req0_addr = 24'd0, req1_addr = 24'd0;
  logic [31:0] req0_wdata = 32'd0, req1_wdata = 32'd0;
  logic        req0_ready, req0_done, req0_err;
  logic        req1_ready, req1_done, req1_err;
  logic        m_enable, m_rst, busy;
  logic [7:0]  m_commands;
  logic [23:0] m_address;
  logic [31:0] m_data_out;
  logic [2:0]  state_dbg;
  logic        m_cs = 1'b1;
  logic        hang = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_flash_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
    .m_enable(m_enable), .m_commands(m_commands), .m_address(m_address), .m_data_out(m_data_out),
    .m_rst(m_rst), .m_cs(m_cs), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // engine model: CS falls one edge after enable, rises FRAME cycles later unless hung
  int eng_cnt = 0;
  always @(posedge clk) begin
    if (m_rst) begin
      m_cs <= 1'b1; eng_cnt <= 0;
    end else if (m_cs && m_enable) begin
      m_cs <= 1'b0; eng_cnt <= FRAME;
    end else if (!m_cs && !hang) begin
      if (eng_cnt == 0) m_cs <= 1'b1;
      else eng_cnt <= eng_cnt - 1;
    end
  end

  // monitors: enable/done activity, CS-high run before each frame, address stability in frame
  int en_cycles = 0, done_cnt = 0, cs_hi = 0, last_gap = 0, addr_bad = 0;
  logic [23:0] frame_addr = 24'd0;
  always @(posedge clk) begin
    if (m_enable) en_cycles <= en_cycles + 1;
    if (req0_done || req1_done) done_cnt <= done_cnt + 1;
    if (m_cs) cs_hi <= cs_hi + 1;
    else begin
      if (cs_hi != 0) begin
        last_gap   <= cs_hi;
        frame_addr <= m_address;
      end else if (m_address !== frame_addr) addr_bad <= addr_bad + 1;
      cs_hi <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sel: 0 done0, 1 done1, 2 not busy, 3 m_rst, 4 any ready
  task automatic wait_until(input int sel, input int budget, output int n);
    logic hit;
    n = 0;
    forever begin
      case (sel)
        0: hit = req0_done;
        1: hit = req1_done;
        2: hit = !busy;
        3: hit = m_rst;
        default: hit = req0_ready || req1_ready;
      endcase
      if (hit || n >= budget) break;
      tick();
      n++;
    end
  endtask

  task automatic run_frame(input int who, input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [31:0] data, input logic err, output int n_done);
    int n;
    wait_until(4, 60, n);
    chk("ready_seen", 64'(n < 60), 64'd1);
    chk("ready_who", {62'd0, req1_ready, req0_ready}, (who == 1) ? 64'd2 : 64'd1);
    tick();
    if (who == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("m_commands", 64'(m_commands), 64'(cmd));
    chk("m_address", 64'(m_address), 64'(addr));
    chk("m_data_out", 64'(m_data_out), 64'(data));
    wait_until(who, 600, n_done);
    chk("done_seen", 64'(n_done < 600), 64'd1);
    chk("err", 64'((who == 1) ? req1_err : req0_err), 64'(err));
  endtask

  initial begin
    int n, snap;
    // reset
    tick(); tick();
    chk("rst_m_rst", 64'(m_rst), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_cmd", 64'(m_commands), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    tick();
    chk("m_rst_low", 64'(m_rst), 64'd0);

    // 1) single write frame, cycle by cycle
    req0_cmd = 8'h56; req0_addr = 24'h123456; req0_wdata = 32'hDEADBEEF; req0_valid = 1'b1;
    tick();
    chk("t1_ready0", 64'(req0_ready), 64'd1);
    chk("t1_ready1", 64'(req1_ready), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_en_grant", 64'(m_enable), 64'd0);
    tick(); req0_valid = 1'b0;
    chk("t1_en_launch", 64'(m_enable), 64'd1);
    chk("t1_cmd", 64'(m_commands), 64'h56);
    chk("t1_addr", 64'(m_address), 64'h123456);
    chk("t1_data", 64'(m_data_out), 64'hDEADBEEF);
    tick();
    chk("t1_cs_low", 64'(m_cs), 64'd0);
    chk("t1_en_hold", 64'(m_enable), 64'd1);
    tick();
    chk("t1_en_off", 64'(m_enable), 64'd0);
    wait_until(0, 100, n);
    chk("t1_done_seen", 64'(n < 100), 64'd1);
    chk("t1_err0", 64'(req0_err), 64'd0);
    chk("t1_cs_high", 64'(m_cs), 64'd1);
    tick();
    chk("t1_gap_busy", 64'(busy), 64'd1);
    wait_until(2, 20, n);
    chk("t1_gap_len", 64'(n), 64'(GAP_CYCLES));

    // 2) simultaneous requests from reset: req0, req1, then req0 again
    rst = 1'b1; tick(); rst = 1'b0; tick();
    req0_cmd = 8'hFF; req0_addr = 24'h000100; req0_wdata = 32'h0;
    req1_cmd = 8'hFF; req1_addr = 24'h000200; req1_wdata = 32'h1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    run_frame(0, 8'hFF, 24'h000100, 32'h0, 1'b0, n);
    run_frame(1, 8'hFF, 24'h000200, 32'h1, 1'b0, n);
    tick();
    req0_addr = 24'h000300; req1_addr = 24'h000400;
    req0_valid = 1'b1; req1_valid = 1'b1;
    run_frame(0, 8'hFF, 24'h000300, 32'h0, 1'b0, n);
    run_frame(1, 8'hFF, 24'h000400, 32'h1, 1'b0, n);
    tick();

    // 3) illegal command: done+err one cycle after ready, engine untouched
    snap = en_cycles;
    req1_cmd = 8'h03; req1_addr = 24'hABCDEF; req1_wdata = 32'h12345678; req1_valid = 1'b1;
    run_frame(1, 8'h03, 24'hABCDEF, 32'h12345678, 1'b1, n);
    chk("t3_done_lat", 64'(n), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_cs", 64'(m_cs), 64'd1);
    tick();
    chk("t3_no_enable", 64'(en_cycles), 64'(snap));

    // 4) hung engine: timeout, recovery reset pulse, error completion, gap
    hang = 1'b1;
    req0_cmd = 8'h56; req0_addr = 24'h000010; req0_valid = 1'b1;
    wait_until(4, 60, n);
    tick(); req0_valid = 1'b0;
    chk("t4_launch", 64'(m_enable), 64'd1);
    wait_until(3, 400, n);
    chk("t4_timeout", 64'(n), 64'(TIMEOUT));
    chk("t4_no_done", 64'(req0_done), 64'd0);
    tick();
    chk("t4_m_rst2", 64'(m_rst), 64'd1);
    chk("t4_done", 64'(req0_done), 64'd1);
    chk("t4_err", 64'(req0_err), 64'd1);
    tick(); hang = 1'b0;
    chk("t4_m_rst_off", 64'(m_rst), 64'd0);
    chk("t4_gap_busy", 64'(busy), 64'd1);
    wait_until(2, 20, n);
    chk("t4_gap_len", 64'(n), 64'(GAP_CYCLES));

    // 5) reset during BUSY: no done, engine reset, then normal service
    req1_cmd = 8'hE9; req1_addr = 24'h000020; req1_valid = 1'b1;
    wait_until(4, 60, n);
    tick(); req1_valid = 1'b0;
    tick(); tick();
    chk("t5_in_busy", 64'(state_dbg), 64'd3);
    chk("t5_cs_low", 64'(m_cs), 64'd0);
    snap = done_cnt;
    rst = 1'b1;
    tick();
    chk("t5_state", 64'(state_dbg), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_m_rst", 64'(m_rst), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("t5_no_done", 64'(done_cnt), 64'(snap));
    chk("t5_cs_idle", 64'(m_cs), 64'd1);
    req0_cmd = 8'h56; req0_addr = 24'h000030; req0_wdata = 32'hCAFEF00D; req0_valid = 1'b1;
    run_frame(0, 8'h56, 24'h000030, 32'hCAFEF00D, 1'b0, n);

    // 6) back-to-back frames: CS-high gap and address stability
    tick();
    snap = addr_bad;
    req0_cmd = 8'hE9; req0_addr = 24'h0A0A0A; req0_wdata = 32'h11112222; req0_valid = 1'b1;
    run_frame(0, 8'hE9, 24'h0A0A0A, 32'h11112222, 1'b0, n);
    tick();
    req0_addr = 24'h0B0B0B; req0_wdata = 32'h33334444; req0_valid = 1'b1;
    run_frame(0, 8'hE9, 24'h0B0B0B, 32'h33334444, 1'b0, n);
    chk("t6_gap_min", 64'(last_gap >= GAP_CYCLES), 64'd1);
    chk("t6_addr_stable", 64'(addr_bad), 64'(snap));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
